// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master controller: FSM states,
// slave address windows and one-hot select codes.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_e;

    localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
    localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
    localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: maps a command address onto a one-hot
// APB select and flags addresses that hit no slave window.
module apb_addr_decode
    import apb_master_pkg::*;
(
    input  logic [31:0] i_addr,
    output logic [2:0]  o_sel,
    output logic        o_valid
);

    always_comb begin
        o_sel   = PSEL_NONE;
        o_valid = 1'b0;
        if (in_range(i_addr, SLV0_BASE, SLV0_LIMIT)) begin
            o_sel   = PSEL_S0;
            o_valid = 1'b1;
        end else if (in_range(i_addr, SLV1_BASE, SLV1_LIMIT)) begin
            o_sel   = PSEL_S1;
            o_valid = 1'b1;
        end else if (in_range(i_addr, SLV2_BASE, SLV2_LIMIT)) begin
            o_sel   = PSEL_S2;
            o_valid = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// Command-to-APB bridge with three decoded slaves. Define APB_PREADY_EN to
// add the Pready input and a TIMEOUT-cycle ACCESS abort counter.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
`ifdef APB_PREADY_EN
    input  logic        Pready,
`endif
    input  logic [31:0] Prdata
);

    apb_state_e  r_state;
    logic        r_live;
    logic [2:0]  r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [2:0]  w_dec_sel;
    logic        w_dec_valid;
    logic        w_done;
    logic        w_abort;
    logic        w_accept;

    apb_addr_decode u_dec (
        .i_addr  (cmd_addr),
        .o_sel   (w_dec_sel),
        .o_valid (w_dec_valid)
    );

`ifdef APB_PREADY_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] r_wait;

    assign w_done  = (r_state == ST_ACCESS) && Pready;
    assign w_abort = (r_state == ST_ACCESS) && !Pready && (r_wait == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)
            r_wait <= '0;
        else if (r_state != ST_ACCESS)
            r_wait <= '0;
        else if (!Pready)
            r_wait <= r_wait + 1'b1;
    end
`else
    assign w_done  = (r_state == ST_ACCESS);
    assign w_abort = 1'b0;
`endif

    // An unmapped command is not taken at ACCESS completion; it waits for IDLE
    // so its error pulse never collides with the finishing transfer's response.
    assign cmd_ready = r_live && ((r_state == ST_IDLE) || (w_done && w_dec_valid));
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state     <= ST_IDLE;
            r_live      <= 1'b0;
            r_psel      <= PSEL_NONE;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_live      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_dec_valid) begin
                            r_state  <= ST_SETUP;
                            r_psel   <= w_dec_sel;
                            r_pwrite <= cmd_write;
                            r_paddr  <= cmd_addr;
                            r_pwdata <= cmd_wdata;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : Prdata;
                        r_penable   <= 1'b0;
                        if (w_accept) begin
                            r_state  <= ST_SETUP;
                            r_psel   <= w_dec_sel;
                            r_pwrite <= cmd_write;
                            r_paddr  <= cmd_addr;
                            r_pwdata <= cmd_wdata;
                        end else begin
                            r_state <= ST_IDLE;
                            r_psel  <= PSEL_NONE;
                        end
                    end else if (w_abort) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_penable   <= 1'b0;
                        r_psel      <= PSEL_NONE;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Pselx     = r_psel;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: responses are predicted into a
// scoreboard at command acceptance and checked when rsp_valid pulses.
module tb_apb_master_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned cyc;
    } exp_t;

    logic        Hclk;
    logic        Hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
`ifdef APB_PREADY_EN
    logic        Pready;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned last_rsp = 0;
    int unsigned prev_rsp = 0;
    exp_t        sb[$];

    apb_master_ctrl #(.TIMEOUT(16)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
`ifdef APB_PREADY_EN
        .Pready    (Pready),
`endif
        .Prdata    (Prdata)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    always @(posedge Hclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        chk({tag, "_Pselx"},     {29'd0, Pselx},     32'd0);
        chk({tag, "_Penable"},   {31'd0, Penable},   32'd0);
        chk({tag, "_Pwrite"},    {31'd0, Pwrite},    32'd0);
        chk({tag, "_Paddr"},     Paddr,              32'd0);
        chk({tag, "_Pwdata"},    Pwdata,             32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata,          32'd0);
    endtask

    // Called just after a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic err, input logic [31:0] rdata,
                        input int unsigned lat, input bit push);
        exp_t e;
        bit   got;
        got       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (cmd_ready === 1'b1) begin
                got = 1'b1;
                if (push) begin
                    e.err   = err;
                    e.rdata = rdata;
                    e.cyc   = cyc + lat;
                    sb.push_back(e);
                end
            end
            @(negedge Hclk);
        end
        cmd_valid = 1'b0;
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL accept_timeout: addr=%h not accepted within 20 cycles", a);
        end
    endtask

    always @(negedge Hclk) begin
        if (rsp_valid === 1'b1) begin
            prev_rsp = last_rsp;
            last_rsp = cyc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_rsp: observed rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_err",     {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_rdata",   rsp_rdata,        e.rdata);
                chk("rsp_latency", cyc,              e.cyc);
            end
        end
        chk("psel_onehot0",   {31'd0, $onehot0(Pselx)},                     32'd1);
        chk("penable_in_sel", {31'd0, (Penable === 1'b1) && (Pselx == 3'b000)}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Hresetn   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        Prdata    = 32'h5555_AAAA;
`ifdef APB_PREADY_EN
        Pready    = 1'b1;
`endif
        #2 Hresetn = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;
        #1 chk("ready_release_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge Hclk);
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // single write
        send(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0, 3, 1'b1);
        chk("wr_setup_psel",   {29'd0, Pselx},   32'd1);
        chk("wr_setup_pen",    {31'd0, Penable}, 32'd0);
        chk("wr_setup_pwrite", {31'd0, Pwrite},  32'd1);
        chk("wr_setup_paddr",  Paddr,            32'h8000_0010);
        chk("wr_setup_pwdata", Pwdata,           32'hDEAD_BEEF);
        chk("wr_setup_ready",  {31'd0, cmd_ready}, 32'd0);
        @(negedge Hclk);
        chk("wr_access_psel",  {29'd0, Pselx},   32'd1);
        chk("wr_access_pen",   {31'd0, Penable}, 32'd1);
        chk("wr_access_paddr", Paddr,            32'h8000_0010);
        chk("wr_access_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge Hclk);
        chk("wr_done_psel",    {29'd0, Pselx},   32'd0);
        chk("wr_done_pen",     {31'd0, Penable}, 32'd0);

        // single read
        Prdata = 32'h0000_00A5;
        send(1'b0, 32'h8400_0004, 32'h0, 1'b0, 32'h0000_00A5, 3, 1'b1);
        chk("rd_setup_psel",   {29'd0, Pselx},  32'd2);
        chk("rd_setup_pwrite", {31'd0, Pwrite}, 32'd0);
        @(negedge Hclk);
        chk("rd_access_pen",   {31'd0, Penable}, 32'd1);
        @(negedge Hclk);
        Prdata = 32'hFFFF_0000;

        // back-to-back write then read, no IDLE bubble
        Prdata = 32'h1234_5678;
        send(1'b1, 32'h8800_0000, 32'hCAFE_F00D, 1'b0, 32'd0, 3, 1'b1);
        chk("b2b_first_psel", {29'd0, Pselx}, 32'd4);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h8000_0000;
        cmd_wdata = 32'h0;
        #1 chk("b2b_setup_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge Hclk);
        chk("b2b_hold_paddr",  Paddr,            32'h8800_0000);
        chk("b2b_hold_pwdata", Pwdata,           32'hCAFE_F00D);
        chk("b2b_hold_pwrite", {31'd0, Pwrite},  32'd1);
        chk("b2b_access_pen",  {31'd0, Penable}, 32'd1);
        send(1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h1234_5678, 3, 1'b1);
        chk("b2b_second_psel", {29'd0, Pselx},   32'd1);
        chk("b2b_second_pen",  {31'd0, Penable}, 32'd0);
        repeat (3) @(negedge Hclk);
        chk("b2b_rsp_gap", last_rsp - prev_rsp, 32'd2);

        // unmapped addresses and window edges
        send(1'b1, 32'h9000_0000, 32'h1111_1111, 1'b1, 32'd0, 1, 1'b1);
        chk("err_psel", {29'd0, Pselx},   32'd0);
        chk("err_pen",  {31'd0, Penable}, 32'd0);
        @(negedge Hclk);
        send(1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'd0, 1, 1'b1);
        chk("err_low_psel", {29'd0, Pselx}, 32'd0);
        @(negedge Hclk);
        send(1'b0, 32'h8C00_0000, 32'h0, 1'b1, 32'd0, 1, 1'b1);
        chk("err_high_psel", {29'd0, Pselx}, 32'd0);
        @(negedge Hclk);
        Prdata = 32'h0BAD_F00D;
        send(1'b0, 32'h8BFF_FFFF, 32'h0, 1'b0, 32'h0BAD_F00D, 3, 1'b1);
        chk("edge_s2_psel", {29'd0, Pselx}, 32'd4);
        repeat (2) @(negedge Hclk);
        send(1'b1, 32'h83FF_FFFF, 32'h2, 1'b0, 32'd0, 3, 1'b1);
        chk("edge_s0_psel", {29'd0, Pselx}, 32'd1);
        repeat (2) @(negedge Hclk);

        // reset during ACCESS drops the transfer
        send(1'b1, 32'h8000_0000, 32'h7777_7777, 1'b0, 32'd0, 3, 1'b0);
        @(negedge Hclk);
        chk("rst_mid_pen", {31'd0, Penable}, 32'd1);
        #2 Hresetn = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(negedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;
        #1 chk("rst_mid_release_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge Hclk);
        chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef APB_PREADY_EN
        // wait states: Pready low for 3 ACCESS cycles
        send(1'b1, 32'h8400_0000, 32'h4444_4444, 1'b0, 32'd0, 6, 1'b1);
        Pready = 1'b0;
        repeat (3) begin
            @(negedge Hclk);
            chk("wait_pen",   {31'd0, Penable},   32'd1);
            chk("wait_ready", {31'd0, cmd_ready}, 32'd0);
        end
        @(negedge Hclk);
        Pready = 1'b1;
        #1 chk("wait_done_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge Hclk);

        // timeout abort
        Prdata = 32'hDDDD_DDDD;
        Pready = 1'b0;
        send(1'b0, 32'h8800_0000, 32'h0, 1'b1, 32'd0, 18, 1'b1);
        repeat (16) @(negedge Hclk);
        chk("tmo_last_pen", {31'd0, Penable}, 32'd1);
        @(negedge Hclk);
        chk("tmo_pen",  {31'd0, Penable}, 32'd0);
        chk("tmo_psel", {29'd0, Pselx},   32'd0);
        Pready = 1'b1;
`endif

        repeat (5) @(negedge Hclk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
